output_csr_decoder: RTL and testbench

OUTPUT_CSR_DECODER -- requirements
Module: output_csr_decoder

---
 rtl/output_csr_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_output_csr_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/output_csr_decoder.sv
// CSR command decoder: pulse timing registers, a pattern-RAM write FIFO and deferred mode switching.
// Define OUTPUT_CSR_DECODER_READBACK_EN to drive sysStatus and keep a saturating overflow counter.
module output_csr_decoder #(
  parameter int SERDES_WIDTH          = 4,
  parameter int COARSE_DELAY_WIDTH    = 22,
  parameter int COARSE_WIDTH_WIDTH    = 22,
  parameter int PATTERN_ADDRESS_WIDTH = 12,
  parameter int FIFO_DEPTH_LOG2       = 2
) (
  input  logic                             sysClk,
  input  logic                             sysReset,
  input  logic                             sysCsrStrobe,
  input  logic [31:0]                      sysGPIO_OUT,
  output logic [1:0]                       mode,
  output logic [COARSE_DELAY_WIDTH-1:0]    coarseDelay,
  output logic [SERDES_WIDTH-1:0]          firstPattern,
  output logic [COARSE_WIDTH_WIDTH-1:0]    coarseWidth,
  output logic [SERDES_WIDTH-1:0]          lastPattern,
  output logic                             patWrValid,
  input  logic                             patWrReady,
  output logic [PATTERN_ADDRESS_WIDTH-1:0] patWrAddr,
  output logic [SERDES_WIDTH-1:0]          patWrData,
  output logic [PATTERN_ADDRESS_WIDTH:0]   patternLength,
  output logic                             configUpdate,
  output logic [31:0]                      sysStatus
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int LW    = FIFO_DEPTH_LOG2 + 1;
  localparam int PAW   = PATTERN_ADDRESS_WIDTH;

  localparam logic [1:0] OP_MODE  = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_WIDTH = 2'b10;
  localparam logic [1:0] OP_PAT   = 2'b11;

  logic [1:0]                    mode_q, mode_d;
  logic [1:0]                    pend_mode_q, pend_mode_d;
  logic                          pend_q, pend_d;
  logic [COARSE_DELAY_WIDTH-1:0] coarse_delay_q, coarse_delay_d;
  logic [SERDES_WIDTH-1:0]       first_pattern_q, first_pattern_d;
  logic [COARSE_WIDTH_WIDTH-1:0] coarse_width_q, coarse_width_d;
  logic [SERDES_WIDTH-1:0]       last_pattern_q, last_pattern_d;
  logic                          cfg_upd_q, cfg_upd_d;
  logic                          ovf_q, ovf_d;
  logic [7:0]                    ovf_cnt_q, ovf_cnt_d;
  logic [FIFO_DEPTH_LOG2-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]                 level_q, level_d;
  logic [PAW:0]                  pat_len_q, pat_len_d;

  logic [PAW-1:0]          fifo_addr_mem [DEPTH];
  logic [SERDES_WIDTH-1:0] fifo_data_mem [DEPTH];

  logic [1:0]     opcode;
  logic           fifo_empty, fifo_full, push_req, push, pop, drop;
  logic [PAW-1:0] head_addr;
  logic [PAW:0]   head_addr_p1;

  assign opcode       = sysGPIO_OUT[31:30];
  assign fifo_empty   = (level_q == '0);
  assign fifo_full    = (level_q == LW'(DEPTH));
  assign push_req     = sysCsrStrobe && (opcode == OP_PAT);
  assign push         = push_req && !fifo_full;
  assign drop         = push_req && fifo_full;
  assign pop          = !fifo_empty && patWrReady;
  assign head_addr    = fifo_addr_mem[rd_ptr_q];
  assign head_addr_p1 = {1'b0, head_addr} + (PAW+1)'(1);

  always_comb begin
    // NOTE: every _d gets a default first so no path through this block can infer a latch.
    mode_d          = mode_q;
    pend_mode_d     = pend_mode_q;
    pend_d          = pend_q;
    coarse_delay_d  = coarse_delay_q;
    first_pattern_d = first_pattern_q;
    coarse_width_d  = coarse_width_q;
    last_pattern_d  = last_pattern_q;
    cfg_upd_d       = 1'b0;
    ovf_d           = ovf_q;
    ovf_cnt_d       = ovf_cnt_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    level_d         = level_q;
    pat_len_d       = pat_len_q;

    // Deferred mode lands once the queued pattern writes have drained.
    if (pend_q && fifo_empty) begin
      mode_d    = pend_mode_q;
      pend_d    = 1'b0;
      cfg_upd_d = 1'b1;
    end

    if (sysCsrStrobe) begin
      unique case (opcode)
        OP_DELAY: begin
          coarse_delay_d  = sysGPIO_OUT[SERDES_WIDTH+COARSE_DELAY_WIDTH-1:SERDES_WIDTH];
          first_pattern_d = sysGPIO_OUT[SERDES_WIDTH-1:0];
          cfg_upd_d       = 1'b1;
        end
        OP_WIDTH: begin
          coarse_width_d = sysGPIO_OUT[SERDES_WIDTH+COARSE_WIDTH_WIDTH-1:SERDES_WIDTH];
          last_pattern_d = sysGPIO_OUT[SERDES_WIDTH-1:0];
          cfg_upd_d      = 1'b1;
        end
        OP_MODE: begin
          if (fifo_empty) begin
            mode_d    = sysGPIO_OUT[1:0];
            pend_d    = 1'b0;
            cfg_upd_d = 1'b1;
          end else begin
            pend_d      = 1'b1;
            pend_mode_d = sysGPIO_OUT[1:0];
          end
          if (sysGPIO_OUT[8]) begin
            ovf_d     = 1'b0;
            ovf_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end

    if (drop) begin
      ovf_d = 1'b1;
      if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (head_addr == '0)             pat_len_d = (PAW+1)'(1);
      else if (head_addr_p1 > pat_len_q) pat_len_d = head_addr_p1;
    end
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (sysReset) begin
      mode_q          <= '0;
      pend_mode_q     <= '0;
      pend_q          <= 1'b0;
      coarse_delay_q  <= '0;
      first_pattern_q <= '0;
      coarse_width_q  <= '0;
      last_pattern_q  <= '0;
      cfg_upd_q       <= 1'b0;
      ovf_q           <= 1'b0;
      ovf_cnt_q       <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      pat_len_q       <= '0;
    end else begin
      mode_q          <= mode_d;
      pend_mode_q     <= pend_mode_d;
      pend_q          <= pend_d;
      coarse_delay_q  <= coarse_delay_d;
      first_pattern_q <= first_pattern_d;
      coarse_width_q  <= coarse_width_d;
      last_pattern_q  <= last_pattern_d;
      cfg_upd_q       <= cfg_upd_d;
      ovf_q           <= ovf_d;
      ovf_cnt_q       <= ovf_cnt_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      pat_len_q       <= pat_len_d;
    end
  end

  // NOTE: FIFO storage has no reset; clearing the pointers and level is enough to discard entries.
  always_ff @(posedge sysClk) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_q] <= sysGPIO_OUT[10+PAW-1:10];
      fifo_data_mem[wr_ptr_q] <= sysGPIO_OUT[SERDES_WIDTH-1:0];
    end
  end

  assign mode          = mode_q;
  assign coarseDelay   = coarse_delay_q;
  assign firstPattern  = first_pattern_q;
  assign coarseWidth   = coarse_width_q;
  assign lastPattern   = last_pattern_q;
  assign patWrValid    = !fifo_empty;
  assign patWrAddr     = head_addr;
  assign patWrData     = fifo_data_mem[rd_ptr_q];
  assign patternLength = pat_len_q;
  assign configUpdate  = cfg_upd_q;

`ifdef OUTPUT_CSR_DECODER_READBACK_EN
  logic unused_gpio;
  assign unused_gpio = ^sysGPIO_OUT;

  always_comb begin
    sysStatus             = '0;
    sysStatus[1:0]        = mode_q;
    sysStatus[2]          = pend_q;
    sysStatus[6:3]        = 4'(level_q);
    sysStatus[7]          = ovf_q;
    sysStatus[15:8]       = ovf_cnt_q;
    sysStatus[16+PAW:16]  = pat_len_q;
  end
`else
  // Without readback the overflow flag and counter have no observer.
  logic unused_state;
  assign unused_state = ^{sysGPIO_OUT, ovf_q, ovf_cnt_q};
  assign sysStatus    = '0;
`endif

endmodule

// File: tb/tb_output_csr_decoder.sv
// Scoreboard bench for output_csr_decoder: directed CSR commands, RAM-write monitor, reset checks.
module tb_output_csr_decoder;

  logic        clk, rst, strobe, ready;
  logic [31:0] gpio;
  logic [1:0]  mode;
  logic [21:0] coarse_delay, coarse_width;
  logic [3:0]  first_pattern, last_pattern, wr_data;
  logic        wr_valid, cfg_upd;
  logic [11:0] wr_addr;
  logic [12:0] pat_len;
  logic [31:0] status;

  output_csr_decoder dut (
    .sysClk(clk), .sysReset(rst), .sysCsrStrobe(strobe), .sysGPIO_OUT(gpio),
    .mode(mode), .coarseDelay(coarse_delay), .firstPattern(first_pattern),
    .coarseWidth(coarse_width), .lastPattern(last_pattern),
    .patWrValid(wr_valid), .patWrReady(ready), .patWrAddr(wr_addr), .patWrData(wr_data),
    .patternLength(pat_len), .configUpdate(cfg_upd), .sysStatus(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [11:0] addr; logic [3:0] data; } wr_t;
  wr_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cu_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write handshake is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && wr_valid && ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
      end
    end
    if (!rst && cfg_upd) cu_count++;
  end

  function automatic logic [31:0] pat_cmd(input logic [11:0] a, input logic [3:0] d);
    return {2'b11, 8'h00, a, 6'h00, d};
  endfunction

  // Called at posedge+1; leaves at the next posedge+1 with the strobe dropped.
  task automatic send(input logic [31:0] w);
    strobe = 1'b1;
    gpio   = w;
    @(posedge clk); #1;
    strobe = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_exp(input logic [11:0] a, input logic [3:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int max);
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !wr_valid) done = 1'b1;
    end
    check(name, done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cu0;
    logic [3:0] d4 [4];
    d4[0] = 4'hF; d4[1] = 4'h1; d4[2] = 4'h0; d4[3] = 4'h0;

    rst = 1'b1; strobe = 1'b0; gpio = '0; ready = 1'b0;
    step(2);
    check("rst_mode", mode, 0);
    check("rst_delay", coarse_delay, 0);
    check("rst_width", coarse_width, 0);
    check("rst_valid", wr_valid, 0);
    check("rst_len", pat_len, 0);
    check("rst_status", status, 0);
    rst = 1'b0;
    step(1);

    // Delay then width commands, each visible the cycle after its strobe.
    cu0 = cu_count;
    send(32'h4000_00AF);
    check("delay", coarse_delay, 22'hA);
    check("first_pat", first_pattern, 4'hF);
    check("delay_cu", cfg_upd, 1);
    check("width_before", coarse_width, 0);
    send(32'h8000_00AF);
    check("width", coarse_width, 22'hA);
    check("last_pat", last_pattern, 4'hF);
    check("width_cu", cfg_upd, 1);
    step(1);
    check("cu_low", cfg_upd, 0);
    check("cu_pulses", cu_count - cu0, 2);

    // Four pattern writes with the RAM always ready.
    ready = 1'b1;
    cu0 = cu_count;
    for (int i = 0; i < 4; i++) begin
      push_exp(12'(i), d4[i]);
      send(pat_cmd(12'(i), d4[i]));
    end
    wait_drain("drain4", 20);
    check("len4", pat_len, 4);
    check("pat_no_cu", cu_count - cu0, 0);

    // Six back-to-back writes into a stalled RAM: four queue, two drop.
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) push_exp(12'(4 + i), 4'(i + 3));
      send(pat_cmd(12'(4 + i), 4'(i + 3)));
    end
    check("stall_valid", wr_valid, 1);
    check("stall_head", wr_addr, 4);
`ifdef OUTPUT_CSR_DECODER_READBACK_EN
    check("ovf_level", status[6:3], 4);
    check("ovf_flag", status[7], 1);
    check("ovf_count", status[15:8], 2);
`else
    check("status_zero", status, 0);
`endif
    ready = 1'b1;
    wait_drain("drain_ovf", 20);
    check("len8", pat_len, 8);

    // Mode writes while two entries are queued stay pending; the later one wins.
    ready = 1'b0;
    push_exp(12'd0, 4'h5);
    send(pat_cmd(12'd0, 4'h5));
    push_exp(12'd1, 4'h6);
    send(pat_cmd(12'd1, 4'h6));
    cu0 = cu_count;
    send(32'h0000_0001);
    send(32'h0000_0003);
    step(3);
    check("pend_mode", mode, 0);
    check("pend_cu", cu_count - cu0, 0);
`ifdef OUTPUT_CSR_DECODER_READBACK_EN
    check("pend_flag", status[2], 1);
    check("pend_level", status[6:3], 2);
`endif
    ready = 1'b1;
    wait_drain("drain_pend", 20);
    step(3);
    check("mode3", mode, 3);
    check("mode3_cu", cu_count - cu0, 1);
    check("len2", pat_len, 2);
`ifdef OUTPUT_CSR_DECODER_READBACK_EN
    check("pend_clear", status[2], 0);
    check("ovf_still", status[7], 1);
`endif

    // Mode 0 with the overflow-clear bit.
    cu0 = cu_count;
    send(32'h0000_0100);
    step(1);
    check("mode0", mode, 0);
    check("mode0_cu", cu_count - cu0, 1);
`ifdef OUTPUT_CSR_DECODER_READBACK_EN
    check("ovf_clr_flag", status[7], 0);
    check("ovf_clr_count", status[15:8], 0);
`endif

    // Asynchronous reset with three entries queued.
    ready = 1'b0;
    send(32'h0000_0002);
    for (int i = 0; i < 3; i++) send(pat_cmd(12'(20 + i), 4'(i)));
    check("pre_rst_valid", wr_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", wr_valid, 0);
    check("arst_mode", mode, 0);
    check("arst_delay", coarse_delay, 0);
    check("arst_first", first_pattern, 0);
    check("arst_width", coarse_width, 0);
    check("arst_last", last_pattern, 0);
    check("arst_len", pat_len, 0);
    check("arst_cu", cfg_upd, 0);
    check("arst_status", status, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready = 1'b1;
    step(5);
    check("post_rst_valid", wr_valid, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
